// File: rtl/poly_pointwise_engine.sv
// Pointwise mod-Q engine: streams N coefficient pairs from poly RAM through a
// LAT-deep pipeline (multiply/add/subtract/scale) and writes reduced results back.
module poly_pointwise_engine #(
  parameter int N       = 512,
  parameter int COEFF_W = 16,
  parameter int Q       = 12289,
  parameter int LAT     = 3,
  parameter int AW      = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [COEFF_W-1:0] scale,
  output logic               busy,
  output logic               done,
  output logic [AW-1:0]      ram_rd_addr,
  input  logic [COEFF_W-1:0] ram_doa,
  input  logic [COEFF_W-1:0] ram_dob,
  output logic [AW-1:0]      ram_wr_addr,
  output logic               ram_we,
  output logic [COEFF_W-1:0] dout
);

  localparam int W2 = 2 * COEFF_W;
  localparam int W4 = 4 * COEFF_W;
  localparam logic [W2-1:0] QW = W2'(Q);

  // Barrett constant floor(2^W2 / Q), built by shift-subtract long division.
  function automatic logic [W4-1:0] barrett_m();
    logic [W4-1:0] r;
    logic [W4-1:0] qt;
    r  = '0;
    qt = '0;
    for (int unsigned i = 0; i <= W2; i++) begin
      r  = {r[W4-2:0], (i == 0)};
      qt = {qt[W4-2:0], 1'b0};
      if (r >= W4'(Q)) begin
        r     = r - W4'(Q);
        qt[0] = 1'b1;
      end
    end
    return qt;
  endfunction

  localparam logic [W4-1:0] BM = barrett_m();

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state, state_nx;
  logic [1:0]           mode_q;
  logic [COEFF_W-1:0]   scale_q;
  logic [AW-1:0]        rd_cnt, wr_cnt;
  logic [LAT:0]         vld;
  logic                 en_q;
  logic [COEFF_W-1:0]   hold_a, hold_b, op_a, op_b;
  logic [W2-1:0]        raw, raw_q, t_est, rem;
  logic [COEFF_W-1:0]   red;
  logic [COEFF_W-1:0]   pipe [0:LAT-2];

  always_ff @(posedge clk) begin
    if (rst)     state <= S_IDLE;
    else if (en) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (rd_cnt == AW'(N - 1)) state_nx = S_DRAIN;
      S_DRAIN: if (vld[LAT] && wr_cnt == AW'(N - 1)) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == S_RUN) || (state == S_DRAIN);
    done   = (state == S_DONE) && en;
    ram_we = vld[LAT] && en;
  end

  // RAM reads are not gated by en: after a stall, replay the operands that
  // were on the RAM outputs when the stall began.
  always_ff @(posedge clk) begin
    if (rst) en_q <= 1'b1;
    else     en_q <= en;
  end

  always_ff @(posedge clk) begin
    hold_a <= op_a;
    hold_b <= op_b;
  end

  always_comb begin
    op_a = en_q ? ram_doa : hold_a;
    op_b = en_q ? ram_dob : hold_b;
    case (mode_q)
      2'b00:   raw = W2'(op_a) * W2'(op_b);
      2'b01:   raw = W2'(op_a) + W2'(op_b);
      2'b10:   raw = W2'(op_a) + QW - W2'(op_b);
      default: raw = W2'(op_a) * W2'(scale_q);
    endcase
  end

  // Quotient estimate is at most one low, so a single correction suffices.
  always_comb begin
    t_est = W2'(({{W2{1'b0}}, raw_q} * BM) >> W2);
    rem   = raw_q - t_est * QW;
    if (rem >= QW) rem = rem - QW;
    red = COEFF_W'(rem);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= '0;
      scale_q <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      vld     <= '0;
      raw_q   <= '0;
      for (int unsigned i = 0; i < LAT - 1; i++) pipe[i] <= '0;
    end else if (en) begin
      if (state == S_IDLE && start) begin
        mode_q  <= mode;
        scale_q <= scale;
        rd_cnt  <= '0;
        wr_cnt  <= '0;
      end
      if (state == S_RUN) rd_cnt <= rd_cnt + 1'b1;
      if (vld[LAT])       wr_cnt <= wr_cnt + 1'b1;
      vld     <= {vld[LAT-1:0], state == S_RUN};
      raw_q   <= raw;
      pipe[0] <= red;
      for (int unsigned i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign ram_rd_addr = rd_cnt;
  assign ram_wr_addr = wr_cnt;
  assign dout        = pipe[LAT-2];

endmodule

// File: tb/tb_poly_pointwise_engine.sv
// Scoreboard bench for poly_pointwise_engine: random operands, per-cycle
// timing model driven by the count of enabled cycles since start.
module tb_poly_pointwise_engine;

  localparam int N   = 512;
  localparam int W   = 16;
  localparam int Q   = 12289;
  localparam int LAT = 3;
  localparam int AW  = 9;

  logic          clk = 1'b0;
  logic          rst, en, start;
  logic [1:0]    mode;
  logic [W-1:0]  scale;
  logic          busy, done, ram_we;
  logic [AW-1:0] ram_rd_addr, ram_wr_addr;
  logic [W-1:0]  ram_doa, ram_dob, dout;

  poly_pointwise_engine #(.N(N), .COEFF_W(W), .Q(Q), .LAT(LAT), .AW(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .scale(scale),
    .busy(busy), .done(done), .ram_rd_addr(ram_rd_addr), .ram_doa(ram_doa),
    .ram_dob(ram_dob), .ram_wr_addr(ram_wr_addr), .ram_we(ram_we), .dout(dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    int unsigned data;
  } exp_t;

  exp_t        sb[$];
  int unsigned mem_a[N];
  int unsigned mem_b[N];
  bit          dob_rand = 1'b0;
  bit          mon_on = 1'b0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM, not gated by en.
  always @(posedge clk) begin
    ram_doa <= W'(mem_a[ram_rd_addr]);
    ram_dob <= dob_rand ? W'($urandom_range(0, Q - 1)) : W'(mem_b[ram_rd_addr]);
  end

  function automatic void check(input string name, input longint unsigned got,
                                input longint unsigned exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic int unsigned ref_op(input logic [1:0] m, input int unsigned a,
                                         input int unsigned b, input int unsigned sc);
    case (m)
      2'b00:   return (a * b) % Q;
      2'b01:   return (a + b) % Q;
      2'b10:   return (a + Q - b) % Q;
      default: return (a * sc) % Q;
    endcase
  endfunction

  // Monitor: en-cycle count since acceptance predicts every output.
  bit          active = 1'b0;
  int unsigned ecount = 0;
  int unsigned wr_run = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        bit   accept, exp_we, exp_done, exp_busy;
        exp_t e;
        accept = !active && start && en && !rst;
        if (active) begin
          exp_we   = en && ecount >= LAT + 1 && ecount <= LAT + N;
          exp_done = en && ecount == LAT + N + 1;
          exp_busy = ecount <= LAT + N;
          check("ram_we", ram_we, exp_we);
          check("done", done, exp_done);
          check("busy", busy, exp_busy);
          if (ecount < N) check("rd_addr", ram_rd_addr, ecount);
          if (ram_we) begin
            wr_run++;
            if (sb.size() == 0) check("sb_nonempty", 0, 1);
            else begin
              e = sb.pop_front();
              check("wr_addr", ram_wr_addr, e.addr);
              check("dout", dout, e.data);
            end
          end
          if (exp_done) begin
            check("write_count", wr_run, N);
            check("sb_drained", sb.size(), 0);
          end
          if (en) ecount++;
          if (rst || exp_done) begin
            active = 1'b0;
            sb.delete();
          end
        end else begin
          check("idle_we", ram_we, 0);
          check("idle_done", done, 0);
          check("idle_busy", busy, 0);
        end
        if (accept) begin
          active = 1'b1;
          ecount = 0;
          wr_run = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input logic [1:0] m, input logic [W-1:0] sc, input bit stalls,
                        input bit abuse, input bit abort, input bit rnd_b);
    int unsigned st[6];
    bit          hit;
    for (int i = 0; i < N; i++) begin
      mem_a[i] = $urandom_range(0, Q - 1);
      mem_b[i] = $urandom_range(0, Q - 1);
    end
    case (m)
      2'b00: begin mem_a[0] = 12288; mem_b[0] = 12288; mem_a[1] = 0; mem_b[1] = 5000; end
      2'b01: begin mem_a[0] = 12288; mem_b[0] = 1; end
      2'b10: begin mem_a[0] = 0; mem_b[0] = 1; mem_a[1] = 5; mem_b[1] = 5; end
      default: begin mem_a[0] = 2; mem_a[1] = 12288; end
    endcase
    for (int i = 0; i < N; i++)
      sb.push_back('{addr: i, data: ref_op(m, mem_a[i], mem_b[i], sc)});
    for (int i = 0; i < 4; i++) st[i] = 20 + i * 100 + $urandom_range(0, 80);
    st[4] = 518;
    st[5] = 519;
    dob_rand = rnd_b;
    mode  = m;
    scale = sc;
    en    = 1'b1;
    start = 1'b1;
    tick();
    hit = 1'b0;
    for (int k = 1; k <= 2000 && !hit; k++) begin
      en    = 1'b1;
      start = abuse && k == 200;
      if (stalls) foreach (st[i]) if (k == st[i]) en = 1'b0;
      if (abuse && k == 300) begin
        mode  = ~m;
        scale = W'($urandom_range(0, Q - 1));
      end
      #1;
      if (abort && ram_we && ram_wr_addr == 100) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hit = 1'b1;
      end else if (done) begin
        tick();
        hit = 1'b1;
      end else begin
        @(posedge clk);
        #2;
      end
    end
    check("run_complete", hit, 1);
    en    = 1'b1;
    start = 1'b0;
    mode  = m;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; mode = 2'b00; scale = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", ram_we, 0);
    check("rst_rd_addr", ram_rd_addr, 0);
    check("rst_wr_addr", ram_wr_addr, 0);
    check("rst_dout", dout, 0);
    rst = 1'b0;
    mon_on = 1'b1;
    tick();
    run_op(2'b00, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(2'b01, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(2'b10, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(2'b11, 16'd6145, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(2'b00, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (20) tick();
    run_op(2'b01, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
